// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback commit queue
package wb_pkg;

    localparam int         WB_QUEUE_DEPTH_DEFAULT = 4;
    localparam logic [4:0] WB_GPR_ZERO            = 5'd0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - 2-push/2-pop circular buffer of GPR writeback entries
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_QUEUE_DEPTH_DEFAULT,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic [1:0]    push_count,
    input  wb_entry_t     push_entry0,
    input  wb_entry_t     push_entry1,
    input  logic [1:0]    pop_count,
    output wb_entry_t     head_entry0,
    output wb_entry_t     head_entry1,
    output logic [CW-1:0] count
);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    assign head_entry0 = mem[head];
    assign head_entry1 = mem[head + PW'(1)];

    // Storage is not reset; an entry is only meaningful while count covers it.
    always_ff @(posedge clk) begin
        if (push_count != 2'd0) begin
            mem[tail] <= push_entry0;
        end
        if (push_count == 2'd2) begin
            mem[tail + PW'(1)] <= push_entry1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_count);
            tail  <= tail + PW'(push_count);
            count <= count + CW'(push_count) - CW'(pop_count);
        end
    end

endmodule

// File: rtl/wb_commit_queue.sv
// rtl/wb_commit_queue.sv - dual-issue writeback commit queue with HI/LO holding register; WB_BYPASS_EN enables the empty-path bypass
module wb_commit_queue
    import wb_pkg::*;
#(
    parameter int QUEUE_DEPTH = WB_QUEUE_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        lane0_valid,
    input  logic        lane1_valid,
    output logic        lane0_ready,
    output logic        lane1_ready,
    input  logic [4:0]  lane0_addr,
    input  logic [4:0]  lane1_addr,
    input  logic [31:0] lane0_data,
    input  logic [31:0] lane1_data,
    input  logic        hilo_valid,
    output logic        hilo_ready,
    input  logic        hilo_hi_we,
    input  logic        hilo_lo_we,
    input  logic [31:0] hilo_hi,
    input  logic [31:0] hilo_lo,
    input  logic        wb_stall,
    output logic [4:0]  write_addr0,
    output logic [4:0]  write_addr1,
    output logic        write_addr0_valid,
    output logic        write_addr1_valid,
    output logic [31:0] write_data0,
    output logic [31:0] write_data1,
    output logic [31:0] write_hilo_hi_data,
    output logic [31:0] write_hilo_lo_data,
    output logic        write_hilo_hi_data_valid,
    output logic        write_hilo_lo_data_valid,
    output logic        wb_busy
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [CW-1:0] count;
    logic          ready;
    logic          acc0;
    logic          acc1;
    logic          bypass;
    logic          hilo_acc;
    logic          hilo_bypass;
    logic [1:0]    in_count;
    logic [1:0]    push_count;
    logic [1:0]    pop_count;
    logic [1:0]    out_count;
    wb_entry_t     in0;
    wb_entry_t     in1;
    wb_entry_t     head0;
    wb_entry_t     head1;
    wb_entry_t     out0;
    wb_entry_t     out1;

    logic          hold_valid;
    logic          hold_hi_we;
    logic          hold_lo_we;
    logic [31:0]   hold_hi;
    logic [31:0]   hold_lo;

    assign ready       = (CW'(QUEUE_DEPTH) - count) >= CW'(2);
    assign lane0_ready = ready;
    assign lane1_ready = ready;
    assign hilo_ready  = !hold_valid;

    // Writes to r0 are architecturally dead, so they never take a slot.
    assign acc0     = lane0_valid && ready && (lane0_addr != WB_GPR_ZERO);
    assign acc1     = lane1_valid && ready && (lane1_addr != WB_GPR_ZERO);
    assign in_count = {1'b0, acc0} + {1'b0, acc1};
    assign hilo_acc = hilo_valid && !hold_valid && (hilo_hi_we || hilo_lo_we);

`ifdef WB_BYPASS_EN
    assign bypass      = (count == '0) && !wb_stall;
    assign hilo_bypass = !wb_stall;
`else
    assign bypass      = 1'b0;
    assign hilo_bypass = 1'b0;
`endif

    always_comb begin
        in0.addr = acc0 ? lane0_addr : lane1_addr;
        in0.data = acc0 ? lane0_data : lane1_data;
        in1.addr = lane1_addr;
        in1.data = lane1_data;
    end

    assign push_count = bypass ? 2'd0 : in_count;
    assign pop_count  = wb_stall ? 2'd0 : ((count >= CW'(2)) ? 2'd2 : 2'(count));

    always_comb begin
        if (bypass) begin
            out_count = in_count;
            out0      = in0;
            out1      = in1;
        end else begin
            out_count = pop_count;
            out0      = head0;
            out1      = head1;
        end
    end

    wb_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk         (clk),
        .rst_        (rst_),
        .push_count  (push_count),
        .push_entry0 (in0),
        .push_entry1 (in1),
        .pop_count   (pop_count),
        .head_entry0 (head0),
        .head_entry1 (head1),
        .count       (count)
    );

    // A same-address pair keeps only the younger write on port 1.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            write_addr0       <= '0;
            write_addr1       <= '0;
            write_data0       <= '0;
            write_data1       <= '0;
            write_addr0_valid <= 1'b0;
            write_addr1_valid <= 1'b0;
        end else begin
            write_addr0_valid <= (out_count != 2'd0) &&
                                 !((out_count == 2'd2) && (out0.addr == out1.addr));
            write_addr1_valid <= (out_count == 2'd2);
            if (out_count != 2'd0) begin
                write_addr0 <= out0.addr;
                write_data0 <= out0.data;
            end
            if (out_count == 2'd2) begin
                write_addr1 <= out1.addr;
                write_data1 <= out1.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            hold_valid               <= 1'b0;
            hold_hi_we               <= 1'b0;
            hold_lo_we               <= 1'b0;
            hold_hi                  <= '0;
            hold_lo                  <= '0;
            write_hilo_hi_data       <= '0;
            write_hilo_lo_data       <= '0;
            write_hilo_hi_data_valid <= 1'b0;
            write_hilo_lo_data_valid <= 1'b0;
        end else begin
            write_hilo_hi_data_valid <= 1'b0;
            write_hilo_lo_data_valid <= 1'b0;
            if (!wb_stall && hold_valid) begin
                write_hilo_hi_data       <= hold_hi;
                write_hilo_lo_data       <= hold_lo;
                write_hilo_hi_data_valid <= hold_hi_we;
                write_hilo_lo_data_valid <= hold_lo_we;
                hold_valid               <= 1'b0;
            end else if (hilo_acc && hilo_bypass) begin
                write_hilo_hi_data       <= hilo_hi;
                write_hilo_lo_data       <= hilo_lo;
                write_hilo_hi_data_valid <= hilo_hi_we;
                write_hilo_lo_data_valid <= hilo_lo_we;
            end else if (hilo_acc) begin
                hold_valid <= 1'b1;
                hold_hi_we <= hilo_hi_we;
                hold_lo_we <= hilo_lo_we;
                hold_hi    <= hilo_hi;
                hold_lo    <= hilo_lo;
            end
        end
    end

    assign wb_busy = (count != '0) || hold_valid || write_addr0_valid || write_addr1_valid ||
                     write_hilo_hi_data_valid || write_hilo_lo_data_valid;

endmodule

// File: tb/tb_wb_commit_queue.sv
// tb/tb_wb_commit_queue.sv - self-checking bench for wb_commit_queue with a queue-level reference model
module tb_wb_commit_queue;

    localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst_;
    logic        lane0_valid, lane1_valid, lane0_ready, lane1_ready;
    logic [4:0]  lane0_addr, lane1_addr;
    logic [31:0] lane0_data, lane1_data;
    logic        hilo_valid, hilo_ready, hilo_hi_we, hilo_lo_we;
    logic [31:0] hilo_hi, hilo_lo;
    logic        wb_stall;
    logic [4:0]  write_addr0, write_addr1;
    logic        write_addr0_valid, write_addr1_valid;
    logic [31:0] write_data0, write_data1;
    logic [31:0] write_hilo_hi_data, write_hilo_lo_data;
    logic        write_hilo_hi_data_valid, write_hilo_lo_data_valid;
    logic        wb_busy;

    int n_checks = 0;
    int n_fail   = 0;

    wb_commit_queue #(.QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_(rst_),
        .lane0_valid(lane0_valid), .lane1_valid(lane1_valid),
        .lane0_ready(lane0_ready), .lane1_ready(lane1_ready),
        .lane0_addr(lane0_addr), .lane1_addr(lane1_addr),
        .lane0_data(lane0_data), .lane1_data(lane1_data),
        .hilo_valid(hilo_valid), .hilo_ready(hilo_ready),
        .hilo_hi_we(hilo_hi_we), .hilo_lo_we(hilo_lo_we),
        .hilo_hi(hilo_hi), .hilo_lo(hilo_lo),
        .wb_stall(wb_stall),
        .write_addr0(write_addr0), .write_addr1(write_addr1),
        .write_addr0_valid(write_addr0_valid), .write_addr1_valid(write_addr1_valid),
        .write_data0(write_data0), .write_data1(write_data1),
        .write_hilo_hi_data(write_hilo_hi_data), .write_hilo_lo_data(write_hilo_lo_data),
        .write_hilo_hi_data_valid(write_hilo_hi_data_valid),
        .write_hilo_lo_data_valid(write_hilo_lo_data_valid),
        .wb_busy(wb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_v0 = 0, m_v1 = 0, m_hv = 0, m_lv = 0;
    logic [4:0]  m_a0 = 0, m_a1 = 0;
    logic [31:0] m_d0 = 0, m_d1 = 0, m_hd = 0, m_ld = 0;
    logic        m_hold = 0, m_hhwe = 0, m_hlwe = 0;
    logic [31:0] m_hhi = 0, m_hlo = 0;

    task automatic model_step();
        ent_t acc[$];
        ent_t outs[$];
        ent_t e;
        bit   rdy;
        bit   hold_before;
        rdy = (DEPTH - mq.size()) >= 2;
        if (lane0_valid && rdy && lane0_addr != 0) begin
            e.addr = lane0_addr; e.data = lane0_data; acc.push_back(e);
        end
        if (lane1_valid && rdy && lane1_addr != 0) begin
            e.addr = lane1_addr; e.data = lane1_data; acc.push_back(e);
        end
        if (!wb_stall) begin
`ifdef WB_BYPASS_EN
            if (mq.size() == 0) begin
                outs = acc;
                acc.delete();
            end
`endif
            while (outs.size() < 2 && mq.size() > 0) outs.push_back(mq.pop_front());
        end
        foreach (acc[i]) mq.push_back(acc[i]);
        m_v1 = (outs.size() == 2);
        m_v0 = (outs.size() >= 1) && !(outs.size() == 2 && outs[0].addr == outs[1].addr);
        if (outs.size() >= 1) begin m_a0 = outs[0].addr; m_d0 = outs[0].data; end
        if (outs.size() == 2) begin m_a1 = outs[1].addr; m_d1 = outs[1].data; end

        hold_before = m_hold;
        m_hv = 0;
        m_lv = 0;
        if (!wb_stall && hold_before) begin
            m_hv = m_hhwe; m_lv = m_hlwe; m_hd = m_hhi; m_ld = m_hlo; m_hold = 0;
        end
        if (hilo_valid && !hold_before && (hilo_hi_we || hilo_lo_we)) begin
`ifdef WB_BYPASS_EN
            if (!wb_stall) begin
                m_hv = hilo_hi_we; m_lv = hilo_lo_we; m_hd = hilo_hi; m_ld = hilo_lo;
            end else
`endif
            begin
                m_hold = 1; m_hhwe = hilo_hi_we; m_hlwe = hilo_lo_we;
                m_hhi = hilo_hi; m_hlo = hilo_lo;
            end
        end
    endtask

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mq.delete();
            m_v0 = 0; m_v1 = 0; m_hv = 0; m_lv = 0; m_hold = 0;
        end else begin
            model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic exp_rdy;
        logic exp_busy;
        exp_rdy  = (DEPTH - mq.size()) >= 2;
        exp_busy = (mq.size() != 0) || m_hold || m_v0 || m_v1 || m_hv || m_lv;
        chk("lane0_ready", lane0_ready, exp_rdy);
        chk("lane1_ready", lane1_ready, exp_rdy);
        chk("hilo_ready", hilo_ready, !m_hold);
        chk("wb_busy", wb_busy, exp_busy);
        chk("write_addr0_valid", write_addr0_valid, m_v0);
        chk("write_addr1_valid", write_addr1_valid, m_v1);
        chk("hi_valid", write_hilo_hi_data_valid, m_hv);
        chk("lo_valid", write_hilo_lo_data_valid, m_lv);
        if (m_v0) begin
            chk("write_addr0", write_addr0, m_a0);
            chk("write_data0", write_data0, m_d0);
        end
        if (m_v1) begin
            chk("write_addr1", write_addr1, m_a1);
            chk("write_data1", write_data1, m_d1);
        end
        if (m_hv) chk("hi_data", write_hilo_hi_data, m_hd);
        if (m_lv) chk("lo_data", write_hilo_lo_data, m_ld);
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        lane0_valid = 0; lane0_addr = 0; lane0_data = 0;
        lane1_valid = 0; lane1_addr = 0; lane1_data = 0;
        hilo_valid = 0; hilo_hi_we = 0; hilo_lo_we = 0; hilo_hi = 0; hilo_lo = 0;
    endtask

    task automatic lanes(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        lane0_valid = v0; lane0_addr = a0; lane0_data = d0;
        lane1_valid = v1; lane1_addr = a1; lane1_data = d1;
    endtask

    initial begin
        idle();
        wb_stall = 0;
        rst_ = 1;
        #1 rst_ = 0;
        repeat (2) step();
        chk("rst_v0", write_addr0_valid, 0);
        chk("rst_a0", write_addr0, 0);
        chk("rst_d1", write_data1, 0);
        chk("rst_hi_valid", write_hilo_hi_data_valid, 0);
        chk("rst_busy", wb_busy, 0);
        rst_ = 1;
        step();
        chk("rst_lane_ready", lane0_ready, 1);
        chk("rst_hilo_ready", hilo_ready, 1);

        // single write
        lanes(1, 5, 32'h1234, 0, 0, 0);
        step(); idle();
        repeat (LAT - 1) step();
        chk("single_v0", write_addr0_valid, 1);
        chk("single_a0", write_addr0, 5);
        chk("single_d0", write_data0, 32'h1234);
        chk("single_v1", write_addr1_valid, 0);
        step();
        chk("single_once", write_addr0_valid, 0);
        repeat (2) step();

        // dual write
        lanes(1, 3, 32'hA, 1, 4, 32'hB);
        step(); idle();
        repeat (LAT - 1) step();
        chk("dual_a0", write_addr0, 3);
        chk("dual_d0", write_data0, 32'hA);
        chk("dual_a1", write_addr1, 4);
        chk("dual_d1", write_data1, 32'hB);
        chk("dual_v", {write_addr0_valid, write_addr1_valid}, 2'b11);
        repeat (3) step();

        // same address
        lanes(1, 7, 32'h1, 1, 7, 32'h2);
        step(); idle();
        repeat (LAT - 1) step();
        chk("same_v0", write_addr0_valid, 0);
        chk("same_v1", write_addr1_valid, 1);
        chk("same_a1", write_addr1, 7);
        chk("same_d1", write_data1, 32'h2);
        repeat (3) step();

        // zero register discarded
        lanes(1, 0, 32'hFFFF, 1, 9, 32'h9);
        step(); idle();
        chk("zero_busy", wb_busy, 1);
        repeat (LAT - 1) step();
        chk("zero_v0", write_addr0_valid, 1);
        chk("zero_a0", write_addr0, 9);
        chk("zero_d0", write_data0, 32'h9);
        chk("zero_v1", write_addr1_valid, 0);
        repeat (3) step();

        // stall fill then drain
        wb_stall = 1;
        lanes(1, 10, 32'h100, 1, 11, 32'h101);
        step();
        lanes(1, 12, 32'h102, 1, 13, 32'h103);
        step();
        chk("fill_ready0", lane0_ready, 0);
        chk("fill_ready1", lane1_ready, 0);
        lanes(1, 14, 32'h104, 1, 15, 32'h105);
        step();
        chk("fill_stall_v0", write_addr0_valid, 0);
        wb_stall = 0; idle();
        step();
        chk("drain1_a0", write_addr0, 10);
        chk("drain1_a1", write_addr1, 11);
        chk("drain1_v", {write_addr0_valid, write_addr1_valid}, 2'b11);
        step();
        chk("drain2_a0", write_addr0, 12);
        chk("drain2_d1", write_data1, 32'h103);
        step();
        chk("drain_busy", wb_busy, 0);
        repeat (2) step();

        // HI/LO hi-only result, then a result with no enables
        hilo_valid = 1; hilo_hi_we = 1; hilo_lo_we = 0; hilo_hi = 32'hDEAD; hilo_lo = 32'hBEEF;
        step(); idle();
        repeat (LAT - 1) step();
        chk("hilo_hv", write_hilo_hi_data_valid, 1);
        chk("hilo_hd", write_hilo_hi_data, 32'hDEAD);
        chk("hilo_lv", write_hilo_lo_data_valid, 0);
        step();
        chk("hilo_once", write_hilo_hi_data_valid, 0);
        hilo_valid = 1; hilo_hi = 32'h5; hilo_lo = 32'h6;
        step(); idle();
        repeat (3) step();

        // directed mixed stream with periodic stalls
        for (int i = 0; i < 24; i++) begin
            lanes((i % 3) != 2, 5'((i * 7) % 32), 32'h1000 + i,
                  (i % 4) != 1, 5'((i * 5 + 3) % 32), 32'h2000 + i);
            wb_stall   = ((i % 6) == 4) || ((i % 6) == 5);
            hilo_valid = (i % 5) == 0;
            hilo_hi_we = i[0];
            hilo_lo_we = i[1];
            hilo_hi    = 32'h3000 + i;
            hilo_lo    = 32'h4000 + i;
            step();
        end
        wb_stall = 0; idle();
        repeat (6) step();
        chk("stream_drained", wb_busy, 0);

        // reset asserted mid-stall
        lanes(1, 20, 32'h20, 1, 21, 32'h21);
        step();
        wb_stall = 1;
        lanes(1, 22, 32'h22, 1, 23, 32'h23);
        hilo_valid = 1; hilo_hi_we = 1; hilo_lo_we = 1; hilo_hi = 32'h11; hilo_lo = 32'h22;
        step();
        chk("pre_rst_hilo_ready", hilo_ready, 0);
        chk("pre_rst_busy", wb_busy, 1);
        #2 rst_ = 0;
        #1;
        chk("rst_async_v0", write_addr0_valid, 0);
        chk("rst_async_v1", write_addr1_valid, 0);
        chk("rst_async_hv", write_hilo_hi_data_valid, 0);
        chk("rst_async_busy", wb_busy, 0);
        chk("rst_async_ready", lane0_ready, 1);
        chk("rst_async_hilo_ready", hilo_ready, 1);
        idle();
        step();
        rst_ = 1; wb_stall = 0;
        step();
        chk("post_rst_ready1", lane1_ready, 1);
        chk("post_rst_hilo_ready", hilo_ready, 1);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_queue.md
# wb_commit_queue

Dual-issue writeback commit queue for the processor core. It accepts completed results from both execution lanes and the multiply/divide unit through valid/ready handshakes. It buffers them in program order and drives the register file's two GPR write ports and its HI/LO write ports. Entries that cannot be written during a writeback stall are held in the queue.

## Interface
- QUEUE_DEPTH, 4: GPR result entries; a power of two, at least 2.
- clk  in  1  core clock; all state updates on rising edge.
- rst_  in  1  asynchronous, active-low reset.
- lane0_valid / lane1_valid  in  1  result present on the lane; lane0 is older than lane1.
- lane0_ready / lane1_ready  out  1  queue can accept; both lanes share the same value.
- lane0_addr / lane1_addr  in  5  destination GPR.
- lane0_data / lane1_data  in  32  result value.
- hilo_valid  in  1  MDU result present.
- hilo_ready  out  1  HI/LO holding register is empty.
- hilo_hi_we / hilo_lo_we  in  1  selects which halves are written.
- hilo_hi / hilo_lo  in  32  MDU result values.
- wb_stall  in  1  blocks all writes while high.
- write_addr0 / write_addr1  out  5  register file write addresses.
- write_addr0_valid / write_addr1_valid  out  1  write enables.
- write_data0 / write_data1  out  32  write data.
- write_hilo_hi_data / write_hilo_lo_data  out  32  HI/LO write data.
- write_hilo_hi_data_valid / write_hilo_lo_data_valid  out  1  HI/LO write enables.
- wb_busy  out  1  high when the queue, the holding register or any output valid is occupied.

## Operation
- Lane accept condition:
  - A lane is accepted when laneX_valid && laneX_ready.
  - laneX_ready = (QUEUE_DEPTH - count) >= 2, computed from registered count only and independent of the valid inputs.
- Push order:
  - When both lanes are accepted, lane0 is pushed before lane1.
  - When only lane1 is valid, lane1 alone is pushed.
  - An accepted entry with addr == 0 is discarded and consumes no slot.
- Pop rule:
  - When !wb_stall, pop min(count, 2) entries, oldest first.
  - The oldest popped entry drives port 0; the second drives port 1.
  - The unused port has its valid deasserted.
- Stall: while wb_stall is high, no pop occurs, all write_* valids are 0, and queue contents are held.
- Same-address pair: if both popped entries share an address, write_addr0_valid is forced to 0 so that the younger write (port 1) is the only write.
- Count and pointers:
  - count' = count + pushes - pops.
  - Pops operate on contents before the push.
  - Head and tail pointers wrap modulo QUEUE_DEPTH.
- HI/LO path:
  - hilo_ready = !hold_valid.
  - An accepted MDU result is latched together with its we bits.
  - The holding register drains to the HI/LO outputs when !wb_stall.
  - Each output valid equals the latched we bit.
  - A result with both we bits 0 is accepted and dropped.
- wb_busy = (count != 0) || hold_valid || any write_* valid.

## Timing
- All write_* outputs are registered.
- Reset values: every output valid is 0, every address/data output is 0, count = 0, hold_valid = 0.
- After reset, lane*_ready = 1 and hilo_ready = 1.
- Accept-to-write latency: accept at the edge ending cycle N gives the write valid in cycle N+2. With bypass enabled on an empty path, the write is valid in cycle N+1.
- Each output valid lasts exactly one cycle per entry; the register file commits it at the following edge.
- Full queue: ready is low whenever fewer than 2 slots are free. No overflow is possible.
- Empty queue with no stall: output valids are 0 in the next cycle.
- Reset asserted mid-operation:
  - All entries and output valids are cleared immediately (asynchronously).
  - Pending results are lost.
  - Upstream reissues after reset.

## Configuration
- WB_BYPASS_EN defined:
  - When count == 0 and !wb_stall, accepted lane entries load the output registers directly and skip the queue. The same-address rule applies.
  - When hold_valid == 0 and !wb_stall, an accepted HI/LO result loads the HI/LO outputs directly.
- WB_BYPASS_EN undefined: every result passes through the queue or the holding register, giving a fixed 2-cycle latency.

## Structure
- Package wb_pkg holds:
  - typedef wb_entry_t {addr[4:0], data[31:0]}
  - constants WB_QUEUE_DEPTH_DEFAULT = 4, WB_GPR_ZERO = 5'd0
- Sub-module wb_queue is the 2-push/2-pop circular buffer with count, head and tail. The top level holds admission, the HI/LO holding register, output registers and bypass muxing.

## Test plan
- Single write: lane0 (addr 5, 0x1234) in one cycle → two cycles later write_addr0 = 5, write_data0 = 0x1234, valid for 1 cycle (1 cycle later with WB_BYPASS_EN).
- Dual write: lane0 (3, 0xA), lane1 (4, 0xB) in the same cycle → port 0 = (3, 0xA) and port 1 = (4, 0xB) in the same cycle.
- Same address: lane0 (7, 0x1), lane1 (7, 0x2) → write_addr0_valid = 0, port 1 writes (7, 0x2).
- Zero register: lane0 (0, 0xFFFF) and lane1 (9, 0x9) → only (9, 0x9) appears, on port 0; count rises by 1.
- Stall fill: hold wb_stall for 3 cycles while pushing 2 entries per cycle → ready drops after 4 entries. On release, writes drain in order as two pairs over 2 cycles, then wb_busy falls.
- HI/LO with reset: hilo result (hi_we = 1, lo_we = 0, hi = 0xDEAD) → only write_hilo_hi_data_valid is asserted, with 0xDEAD. rst_ low mid-stall → all valids 0 immediately and both ready signals 1 after release.
